// File: rtl/serial_link_partner.sv
// Far-end peer of the DMG link cable: exchanges one byte per transfer, MSB first,
// either following the DMG's SCK (slave) or generating SCK itself (master).
// Ports:
//   clk, nreset        system clock, synchronous active-low reset
//   sck_in, sout_in    link SCK and DMG serial data from the pads (asynchronous)
//   sin_out            serial data back to the DMG
//   sck_out, sck_oe    generated SCK level and its drive enable (master mode)
//   master             clock mode, captured when a load is accepted
//   tx_data, tx_load   byte to send and its one-cycle load strobe
//   busy               transfer in progress
//   rx_data, rx_valid  last received byte and its one-cycle update pulse
module serial_link_partner #(
    parameter int unsigned DIV_HALF = 64
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       sck_in,
    input  logic       sout_in,
    output logic       sin_out,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       master,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int unsigned TW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic          sck_s1, sck_s2, sck_prev;
    logic          sout_s1, sout_s2;
    logic [7:0]    sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mode_q, mode_d;
    logic          sin_out_d, sck_out_d, sck_oe_d, busy_d, rx_valid_d;
    logic [7:0]    rx_data_d;
    logic          sck_rise, sck_fall, wrap;

    // Synchronizers, SCK history and all state/output registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_prev <= 1'b1;
            sout_s1  <= 1'b1;
            sout_s2  <= 1'b1;
            state_q  <= IDLE;
            sr_q     <= 8'hFF;
            cnt_q    <= '0;
            timer_q  <= '0;
            mode_q   <= 1'b0;
            sin_out  <= 1'b1;
            sck_out  <= 1'b1;
            sck_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            sck_s1   <= sck_in;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            sout_s1  <= sout_in;
            sout_s2  <= sout_s1;
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            mode_q   <= mode_d;
            sin_out  <= sin_out_d;
            sck_out  <= sck_out_d;
            sck_oe   <= sck_oe_d;
            busy     <= busy_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        mode_d     = mode_q;
        sin_out_d  = sin_out;
        sck_out_d  = sck_out;
        sck_oe_d   = sck_oe;
        busy_d     = busy;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        wrap       = 1'b0;

        case (state_q)
            IDLE: begin
                // Idle line is high, so an unloaded partner answers 8'hFF
                sin_out_d = 1'b1;
                // rx_valid marks the completing cycle; a load there is dropped
                if (tx_load && !rx_valid) begin
                    sr_d      = tx_data;
                    sin_out_d = tx_data[7];
                    cnt_d     = '0;
                    timer_d   = '0;
                    mode_d    = master;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                    if (master) begin
                        sck_oe_d  = 1'b1;
                        sck_out_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (mode_q) begin
                    // Half-period timer; each wrap toggles the generated SCK
                    wrap    = (timer_q == TW'(DIV_HALF - 1));
                    timer_d = wrap ? '0 : timer_q + TW'(1);
                    if (wrap) begin
                        sck_out_d = ~sck_out;
                        sck_rise  = ~sck_out;
                        sck_fall  = sck_out;
                    end
                end else begin
                    sck_rise = sck_s2 & ~sck_prev;
                    sck_fall = ~sck_s2 & sck_prev;
                end

                if (sck_fall) begin
                    sin_out_d = sr_q[7];
                end

                if (sck_rise) begin
                    sr_d  = {sr_q[6:0], sout_s2};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(7)) begin
                        rx_data_d  = {sr_q[6:0], sout_s2};
                        rx_valid_d = 1'b1;
                        busy_d     = 1'b0;
                        sck_oe_d   = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_link_partner.sv
// Self-checking bench for serial_link_partner: a small DMG serial-port model
// drives the link in both clock modes; received bytes go through a scoreboard.
`timescale 1ns/1ps
module tb_serial_link_partner;

    localparam int unsigned DIV   = 4;
    localparam int unsigned HALF  = 6;

    logic       clk = 1'b0;
    logic       nreset;
    logic       sck_in, sout_in, sin_out, sck_out, sck_oe;
    logic       master, tx_load, busy, rx_valid;
    logic [7:0] tx_data, rx_data;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q[$];
    logic prev_rv = 1'b0;
    logic prev_busy = 1'b0;

    serial_link_partner #(.DIV_HALF(DIV)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .sck_in   (sck_in),
        .sout_in  (sout_in),
        .sin_out  (sin_out),
        .sck_out  (sck_out),
        .sck_oe   (sck_oe),
        .master   (master),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d, input logic m);
        tx_data = d;
        master  = m;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // DMG on internal clock: data out on falling SCK, sample on rising SCK
    task automatic dmg_int(input logic [7:0] dout, input int nbits, output logic [7:0] din);
        din = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck_in  = 1'b0;
            sout_in = dout[7-i];
            tick(HALF);
            sck_in = 1'b1;
            din    = {din[6:0], sin_out};
            if (i < nbits - 1) tick(HALF);
        end
    endtask

    task automatic wait_rx(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Scoreboard and rx_valid protocol monitor
    always @(negedge clk) begin
        if (nreset && rx_valid) begin
            rx_cnt++;
            check("rv_busy_low", busy, 0);
            check("rv_busy_was_high", prev_busy, 1);
            check("rv_single_pulse", prev_rv, 0);
            if (exp_q.size() == 0)
                check("rx_unexpected", exp_q.size(), 1);
            else
                check("rx_data", rx_data, exp_q.pop_front());
        end
        prev_rv   = rx_valid;
        prev_busy = busy;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] din;
        logic       ok;
        int         rc0;
        int         oe_cnt, falls, rises, rv_at;
        logic       prev_sck, irq;

        nreset = 1'b0; sck_in = 1'b1; sout_in = 1'b1;
        master = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        tick(3);
        check("rst_sin_out", sin_out, 1);
        check("rst_sck_out", sck_out, 1);
        check("rst_sck_oe", sck_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        nreset = 1'b1;
        tick(5);

        // 1: slave exchange
        exp_q.push_back(8'h3C);
        load(8'hA5, 1'b0);
        check("t1_busy", busy, 1);
        dmg_int(8'h3C, 8, din);
        check("t1_dmg_sb", din, 8'hA5);
        wait_rx(ok);
        check("t1_rx_seen", ok, 1);
        tick(2);
        check("t1_idle_sin", sin_out, 1);

        // 2: master exchange, DMG on external clock
        sout_in  = 1'b1;
        exp_q.push_back(8'h7E);
        tx_data  = 8'h81;
        master   = 1'b1;
        tx_load  = 1'b1;
        oe_cnt = 0; falls = 0; rises = 0; rv_at = -1;
        prev_sck = 1'b1; irq = 1'b0; din = 8'h00;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            tx_load = 1'b0;
            if (sck_oe) oe_cnt++;
            if (prev_sck && !sck_out) begin
                if (falls < 8) sout_in = tx_data[0] ? 1'b0 : 1'b0;
                if (falls < 8) sout_in = (8'h7E >> (7 - falls)) & 8'h01;
                falls++;
            end
            if (!prev_sck && sck_out) begin
                din = {din[6:0], sin_out};
                rises++;
                if (rises == 8) irq = 1'b1;
            end
            if (rx_valid && rv_at < 0) rv_at = c;
            prev_sck = sck_out;
            if (rv_at >= 0 && c >= rv_at + 3) break;
        end
        master = 1'b0;
        check("t2_oe_cycles", oe_cnt, 16 * DIV);
        check("t2_low_pulses", falls, 8);
        check("t2_rises", rises, 8);
        check("t2_rv_latency", rv_at, 16 * DIV);
        check("t2_dmg_sb", din, 8'h81);
        check("t2_dmg_irq", irq, 1);
        check("t2_sck_end_high", sck_out, 1);
        check("t2_oe_end", sck_oe, 0);

        // 3: unloaded partner
        rc0 = rx_cnt;
        dmg_int(8'h55, 8, din);
        tick(10);
        check("t3_dmg_sb", din, 8'hFF);
        check("t3_no_rx", rx_cnt, rc0);
        check("t3_busy", busy, 0);

        // 4: loads while busy and in the rx_valid cycle are ignored
        exp_q.push_back(8'h18);
        load(8'hE7, 1'b0);
        fork
            dmg_int(8'h18, 8, din);
            begin
                tick(20);
                tx_data = 8'h00;
                tx_load = 1'b1;
                master  = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(3);
                check("t4_busy_mid", busy, 1);
                check("t4_oe_slave", sck_oe, 0);
                master = 1'b0;
            end
        join
        check("t4_dmg_sb", din, 8'hE7);
        wait_rx(ok);
        check("t4_rx_seen", ok, 1);
        tx_data = 8'h00;
        tx_load = 1'b1;
        tick(1);
        check("t4_rv_load_ignored", busy, 0);
        exp_q.push_back(8'hF0);
        tx_data = 8'h69;
        tick(1);
        tx_load = 1'b0;
        check("t4_reload_busy", busy, 1);
        check("t4_reload_bit7", sin_out, 0);
        dmg_int(8'hF0, 8, din);
        check("t4_dmg_sb2", din, 8'h69);
        wait_rx(ok);
        check("t4_rx2_seen", ok, 1);
        tick(3);

        // 5: reset mid-transfer
        rc0 = rx_cnt;
        load(8'h5A, 1'b0);
        dmg_int(8'hAA, 4, din);
        tick(4);
        nreset = 1'b0;
        tick(1);
        check("t5_busy", busy, 0);
        check("t5_sin_out", sin_out, 1);
        check("t5_sck_oe", sck_oe, 0);
        check("t5_rx_data", rx_data, 8'h00);
        nreset = 1'b1;
        tick(10);
        check("t5_no_rx", rx_cnt, rc0);
        exp_q.push_back(8'h99);
        load(8'hC3, 1'b0);
        dmg_int(8'h99, 8, din);
        check("t5_dmg_sb", din, 8'hC3);
        wait_rx(ok);
        check("t5_rx_seen", ok, 1);
        tick(3);

        // 6: back-to-back slave transfers
        exp_q.push_back(8'h12);
        load(8'hAB, 1'b0);
        dmg_int(8'h12, 8, din);
        check("t6_dmg_sb1", din, 8'hAB);
        wait_rx(ok);
        check("t6_rx1_seen", ok, 1);
        tick(1);
        exp_q.push_back(8'h34);
        load(8'hCD, 1'b0);
        check("t6_busy2", busy, 1);
        dmg_int(8'h34, 8, din);
        check("t6_dmg_sb2", din, 8'hCD);
        wait_rx(ok);
        check("t6_rx2_seen", ok, 1);

        tick(10);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
